qpsk_mapper: RTL and testbench

- Downstream neighbour of the interleaver ping-pong buffer in the WiMAX PHY channel-coding chain.
- Consumes the serial interleaved bit stream (192 bits per block) under a valid/ready handshake.
- Groups the stream into bit pairs and maps each pair to a Gray-coded QPSK symbol as signed fixed-point I/Q.
- Registers each symbol with its own valid/ready handshake toward the IFFT/framing stage and flags the last symbol of each block.

---
 rtl/qpsk_mapper_if.sv | 24 ++
 rtl/qpsk_mapper.sv | 86 ++++++++
 tb/tb_qpsk_mapper.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/qpsk_mapper_if.sv
// Stream interface between the interleaver bit source, the QPSK mapper and the IFFT/framing sink.
// master = mapper side (consumes bits, produces symbols); slave = surrounding environment.
interface qpsk_mapper_if #(
  parameter int DATA_W = 16
);
  logic                     data_in;
  logic                     valid_in;
  logic                     ready_out;
  logic signed [DATA_W-1:0] I_out;
  logic signed [DATA_W-1:0] Q_out;
  logic                     valid_out;
  logic                     ready_in;
  logic                     last_out;

  modport master (
    input  data_in, valid_in, ready_in,
    output ready_out, I_out, Q_out, valid_out, last_out
  );

  modport slave (
    output data_in, valid_in, ready_in,
    input  ready_out, I_out, Q_out, valid_out, last_out
  );
endinterface

// File: rtl/qpsk_mapper.sv
// Gray-coded QPSK mapper: pairs serial bits into signed I/Q symbols with a registered
// output stage and a last-of-block flag every BLOCK_SYMS symbols.
//
//   state | meaning
//   BIT0  | waiting for first bit of a pair (drives I); always ready
//   BIT1  | first bit held in b0_q, waiting for second bit (drives Q) and a free output slot
module qpsk_mapper #(
  parameter int DATA_W     = 16,
  parameter int AMP        = 23170,
  parameter int BLOCK_SYMS = 96
) (
  input  logic          clk,
  input  logic          reset,
  qpsk_mapper_if.master bus
);

  localparam int                       CNT_W    = (BLOCK_SYMS > 1) ? $clog2(BLOCK_SYMS) : 1;
  localparam logic [CNT_W-1:0]         LAST_IDX = CNT_W'(BLOCK_SYMS - 1);
  localparam logic signed [DATA_W-1:0] POS      = DATA_W'(AMP);
  localparam logic signed [DATA_W-1:0] NEG      = DATA_W'(-AMP);

  typedef enum logic {BIT0, BIT1} state_t;

  state_t                   state_q;
  logic                     b0_q;
  logic [CNT_W-1:0]         sym_cnt_q;
  logic                     valid_q;
  logic                     last_q;
  logic signed [DATA_W-1:0] i_q;
  logic signed [DATA_W-1:0] q_q;

  logic                     ready_d;
  logic                     in_xfer;
  logic                     load;
  logic                     out_xfer;
  logic signed [DATA_W-1:0] i_d;
  logic signed [DATA_W-1:0] q_d;

  // BIT1 may only complete a pair when the output slot is empty or draining this cycle
  assign ready_d  = ~reset & ((state_q == BIT0) | ~valid_q | bus.ready_in);
  assign in_xfer  = bus.valid_in & ready_d;
  assign load     = in_xfer & (state_q == BIT1);
  assign out_xfer = valid_q & bus.ready_in;
  assign i_d      = b0_q ? NEG : POS;
  assign q_d      = bus.data_in ? NEG : POS;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= BIT0;
      b0_q      <= 1'b0;
      sym_cnt_q <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      i_q       <= '0;
      q_q       <= '0;
    end else begin
      case (state_q)
        BIT0: if (in_xfer) begin
          b0_q    <= bus.data_in;
          state_q <= BIT1;
        end
        BIT1: if (in_xfer) begin
          state_q <= BIT0;
        end
        default: state_q <= BIT0;
      endcase

      if (load) begin
        i_q       <= i_d;
        q_q       <= q_d;
        valid_q   <= 1'b1;
        last_q    <= (sym_cnt_q == LAST_IDX);
        sym_cnt_q <= (sym_cnt_q == LAST_IDX) ? '0 : sym_cnt_q + 1'b1;
      end else if (out_xfer) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.ready_out = ready_d;
  assign bus.I_out     = i_q;
  assign bus.Q_out     = q_q;
  assign bus.valid_out = valid_q;
  assign bus.last_out  = last_q;

endmodule

// File: tb/tb_qpsk_mapper.sv
// Directed bench for qpsk_mapper: fixed pair vectors, full blocks, backpressure, random
// handshakes, mid-stream reset and a reduced-width instance.
module tb_qpsk_mapper;

  localparam int AMP = 23170;

  typedef struct {
    int i;
    int q;
    int last;
  } sym_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  qpsk_mapper_if #(.DATA_W(16)) bus ();
  qpsk_mapper_if #(.DATA_W(12)) bus_s ();

  qpsk_mapper #(.DATA_W(16), .AMP(23170), .BLOCK_SYMS(96)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  qpsk_mapper #(.DATA_W(12), .AMP(1000), .BLOCK_SYMS(96)) dut_s (
    .clk(clk), .reset(reset), .bus(bus_s)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_err = 0;
  int   n_sym, n_last, n_bits, m_cnt;
  logic have_b0, m_b0;
  sym_t exp_q[$];

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    have_b0 = 1'b0;
    m_b0    = 1'b0;
    m_cnt   = 0;
    n_sym   = 0;
    n_last  = 0;
    n_bits  = 0;
  endtask

  // Reference model and scoreboard, sampled mid-cycle: observes what the next edge will transfer
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.valid_out && bus.ready_in) begin
        n_sym++;
        if (bus.last_out) n_last++;
        check("sym_avail", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          sym_t e;
          e = exp_q.pop_front();
          check("sym_I", int'(bus.I_out), e.i);
          check("sym_Q", int'(bus.Q_out), e.q);
          check("sym_last", int'(bus.last_out), e.last);
        end
      end
      if (bus.valid_in && bus.ready_out) begin
        n_bits++;
        if (!have_b0) begin
          m_b0    = bus.data_in;
          have_b0 = 1'b1;
        end else begin
          sym_t s;
          s.i    = m_b0 ? -AMP : AMP;
          s.q    = bus.data_in ? -AMP : AMP;
          s.last = (m_cnt == 95) ? 1 : 0;
          exp_q.push_back(s);
          m_cnt   = (m_cnt == 95) ? 0 : m_cnt + 1;
          have_b0 = 1'b0;
        end
      end
    end
  end

  task automatic do_reset();
    reset          = 1'b1;
    bus.valid_in   = 1'b0;
    bus.data_in    = 1'b0;
    bus.ready_in   = 1'b0;
    bus_s.valid_in = 1'b0;
    bus_s.data_in  = 1'b0;
    bus_s.ready_in = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    check("rst_valid", int'(bus.valid_out), 0);
    check("rst_I", int'(bus.I_out), 0);
    check("rst_Q", int'(bus.Q_out), 0);
    check("rst_last", int'(bus.last_out), 0);
    check("rst_ready", int'(bus.ready_out), 0);
    reset = 1'b0;
    #1;
    check("rel_ready", int'(bus.ready_out), 1);
  endtask

  task automatic send_bit(input logic b);
    bus.valid_in = 1'b1;
    bus.data_in  = b;
    @(posedge clk);
    #1;
    bus.valid_in = 1'b0;
  endtask

  int vec_b[8] = '{0, 0, 0, 1, 1, 0, 1, 1};
  int vec_i[4] = '{AMP, AMP, -AMP, -AMP};
  int vec_q[4] = '{AMP, -AMP, AMP, -AMP};
  int cyc;

  initial begin
    bus.valid_in = 1'b0; bus.data_in = 1'b0; bus.ready_in = 1'b0;
    bus_s.valid_in = 1'b0; bus_s.data_in = 1'b0; bus_s.ready_in = 1'b0;
    model_clear();
    #12;

    // Four Gray pairs, one-cycle latency, full rate
    do_reset();
    bus.ready_in = 1'b1;
    for (int k = 0; k < 8; k++) begin
      bus.valid_in = 1'b1;
      bus.data_in  = vec_b[k][0];
      #1;
      check("t1_ready", int'(bus.ready_out), 1);
      @(posedge clk);
      #1;
      if (k % 2 == 1) begin
        check("t1_valid", int'(bus.valid_out), 1);
        check("t1_I", int'(bus.I_out), vec_i[k/2]);
        check("t1_Q", int'(bus.Q_out), vec_q[k/2]);
      end else if (k > 0) begin
        check("t1_release", int'(bus.valid_out), 0);
      end
    end
    bus.valid_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("t1_drain", exp_q.size(), 0);

    // Full block plus two symbols of the next one
    do_reset();
    bus.ready_in = 1'b1;
    for (int k = 0; k < 196; k++) send_bit(1'($urandom_range(0, 1)));
    repeat (2) @(posedge clk);
    #1;
    check("t2_nsym", n_sym, 98);
    check("t2_nlast", n_last, 1);
    check("t2_drain", exp_q.size(), 0);

    // Backpressure for 10 cycles after the first symbol
    do_reset();
    bus.ready_in = 1'b1;
    send_bit(1'b0);
    send_bit(1'b1);
    check("t3_valid0", int'(bus.valid_out), 1);
    bus.ready_in = 1'b0;
    bus.valid_in = 1'b1;
    bus.data_in  = 1'b1;
    #1;
    check("t3_accept", int'(bus.ready_out), 1);
    @(posedge clk);
    #1;
    bus.data_in = 1'bx;
    for (int c = 1; c < 10; c++) begin
      #1;
      check("t3_stall_ready", int'(bus.ready_out), 0);
      check("t3_hold_valid", int'(bus.valid_out), 1);
      check("t3_hold_I", int'(bus.I_out), AMP);
      check("t3_hold_Q", int'(bus.Q_out), -AMP);
      @(posedge clk);
      #1;
    end
    bus.ready_in = 1'b1;
    bus.data_in  = 1'b0;
    #1;
    check("t3_resume_ready", int'(bus.ready_out), 1);
    @(posedge clk);
    #1;
    bus.valid_in = 1'b0;
    check("t3_nobubble", int'(bus.valid_out), 1);
    check("t3_next_I", int'(bus.I_out), -AMP);
    check("t3_next_Q", int'(bus.Q_out), AMP);
    repeat (2) @(posedge clk);
    #1;
    check("t3_nsym", n_sym, 2);

    // Random valid/ready for two full blocks
    do_reset();
    cyc = 0;
    while (n_sym < 192 && cyc < 5000) begin
      bus.valid_in = (n_bits < 384) ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.data_in  = 1'($urandom_range(0, 1));
      bus.ready_in = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.valid_in = 1'b0;
    check("t4_nsym", n_sym, 192);
    check("t4_nlast", n_last, 2);
    check("t4_drain", exp_q.size(), 0);

    // Reset with a held symbol and a half pair pending
    do_reset();
    bus.ready_in = 1'b0;
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    check("t5_pending", int'(bus.valid_out), 1);
    reset = 1'b1;
    model_clear();
    #1;
    check("t5_rst_valid", int'(bus.valid_out), 0);
    check("t5_rst_I", int'(bus.I_out), 0);
    check("t5_rst_Q", int'(bus.Q_out), 0);
    check("t5_rst_ready", int'(bus.ready_out), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.ready_in = 1'b1;
    send_bit(1'b1);
    send_bit(1'b1);
    check("t5_I", int'(bus.I_out), -AMP);
    check("t5_Q", int'(bus.Q_out), -AMP);
    check("t5_last", int'(bus.last_out), 0);
    for (int k = 0; k < 190; k++) send_bit(1'($urandom_range(0, 1)));
    repeat (2) @(posedge clk);
    #1;
    check("t5_nsym", n_sym, 96);
    check("t5_nlast", n_last, 1);

    // 12-bit instance with AMP=1000
    do_reset();
    bus_s.ready_in = 1'b1;
    bus_s.valid_in = 1'b1;
    bus_s.data_in  = 1'b0;
    #1;
    check("t6_ready", int'(bus_s.ready_out), 1);
    @(posedge clk);
    #1;
    bus_s.data_in = 1'b1;
    @(posedge clk);
    #1;
    check("t6_valid", int'(bus_s.valid_out), 1);
    check("t6_I_pos", int'(unsigned'(bus_s.I_out)), 'h3E8);
    check("t6_Q_neg", int'(unsigned'(bus_s.Q_out)), 'hC18);
    bus_s.data_in = 1'b1;
    @(posedge clk);
    #1;
    bus_s.data_in = 1'b0;
    @(posedge clk);
    #1;
    bus_s.valid_in = 1'b0;
    check("t6_I_neg", int'(unsigned'(bus_s.I_out)), 'hC18);
    check("t6_Q_pos", int'(unsigned'(bus_s.Q_out)), 'h3E8);
    check("t6_I_signed", int'(bus_s.I_out), -1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
